// File: rtl/basys3_7seg_pkg.sv
// Shared types for the Basys3 7-segment display scheduler.
package basys3_7seg_pkg;

    typedef logic [3:0] digit_t;

    typedef digit_t [3:0] disp_word_t;

    typedef enum logic [1:0] {
        LIVE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/basys3_7seg_lzb.sv
// Leading-zero blanker: masks high digits that are zero above the first non-zero one.
module basys3_7seg_lzb
    import basys3_7seg_pkg::*;
(
    input  logic [15:0] value_i,
    input  logic        blank_i,
    output logic [3:0]  en_o
);

    disp_word_t word;
    assign word = value_i;

    always_comb begin
        en_o = 4'hF;
        if (blank_i) begin
            // digit0 always stays lit so a zero value still shows "0"
            en_o[3] = (word[3] != 4'd0);
            en_o[2] = ((word[3] | word[2]) != 4'd0);
            en_o[1] = ((word[3] | word[2] | word[1]) != 4'd0);
        end
    end

endmodule

// File: rtl/basys3_7seg_sched.sv
// Display scheduler: shares the 4-digit display between a live value and
// one-shot messages with hold, gap and blink sequencing.
module basys3_7seg_sched
    import basys3_7seg_pkg::*;
#(
    parameter int HOLD_MS       = 2000,
    parameter int GAP_MS        = 100,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic        clk_1k_i,
    input  logic        rst_i,
    input  logic [15:0] live_i,
    input  logic        lz_blank_i,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [15:0] msg_i,
    input  logic [3:0]  msg_en_i,
    input  logic        msg_blink_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        digit0_en_o,
    output logic        digit1_en_o,
    output logic        digit2_en_o,
    output logic        digit3_en_o,
    output logic [3:0]  digit0_o,
    output logic [3:0]  digit1_o,
    output logic [3:0]  digit2_o,
    output logic [3:0]  digit3_o
);

    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int GW = $clog2(((GAP_MS > 0) ? GAP_MS : 1) + 1);
    localparam int BW = $clog2(BLINK_HALF_MS + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_MS > 0) ? GAP_MS - 1 : 0);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_MS - 1);

    sched_state_e  state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    disp_word_t    msg_q, msg_d;
    logic [3:0]    msg_en_q, msg_en_d;
    logic          msg_blink_q, msg_blink_d;
    disp_word_t    disp_q, disp_d;
    logic [3:0]    en_q, en_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [3:0]    live_en;

    basys3_7seg_lzb u_lzb (
        .value_i (live_i),
        .blank_i (lz_blank_i),
        .en_o    (live_en)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        msg_d       = msg_q;
        msg_en_d    = msg_en_q;
        msg_blink_d = msg_blink_q;

        case (state_q)
            LIVE: begin
                if (msg_valid_i && ready_q) begin
                    state_d     = SHOW;
                    msg_d       = msg_i;
                    msg_en_d    = msg_en_i;
                    msg_blink_d = msg_blink_i;
                end
            end
            SHOW: begin
                if (abort_i) begin
                    state_d = LIVE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = (GAP_MS == 0) ? LIVE : GAP;
                end else begin
                    hold_d = hold_q + 1'b1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort_i || gap_q == GAP_LAST) begin
                    state_d = LIVE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = LIVE;
        endcase

        // Every state entry restarts all sequencing counters, blink phase on.
        if (state_d != state_q) begin
            hold_d      = '0;
            gap_d       = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end

        disp_d = '0;
        en_d   = 4'h0;
        case (state_d)
            LIVE: begin
                disp_d = live_i;
                en_d   = live_en;
            end
            SHOW: begin
                disp_d = msg_d;
                en_d   = msg_en_d & {4{blink_on_d | ~msg_blink_d}};
            end
            default: ;
        endcase

        ready_d = (state_d == LIVE);
        busy_d  = (state_d != LIVE);
    end

    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= LIVE;
            hold_q      <= '0;
            gap_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
            msg_q       <= '0;
            msg_en_q    <= 4'h0;
            msg_blink_q <= 1'b0;
            disp_q      <= '0;
            en_q        <= 4'h0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            msg_q       <= msg_d;
            msg_en_q    <= msg_en_d;
            msg_blink_q <= msg_blink_d;
            disp_q      <= disp_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign msg_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign digit0_en_o = en_q[0];
    assign digit1_en_o = en_q[1];
    assign digit2_en_o = en_q[2];
    assign digit3_en_o = en_q[3];
    assign digit0_o    = disp_q[0];
    assign digit1_o    = disp_q[1];
    assign digit2_o    = disp_q[2];
    assign digit3_o    = disp_q[3];

endmodule

// File: tb/tb_basys3_7seg_sched.sv
// Scoreboard bench for basys3_7seg_sched: directed scenarios then random traffic.
module tb_basys3_7seg_sched;

    localparam int HOLD = 8;
    localparam int GAP  = 2;
    localparam int HALF = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] live_i = 16'h0;
    logic        lz_blank_i = 1'b0;
    logic        msg_valid_i = 1'b0;
    logic        msg_ready_o;
    logic [15:0] msg_i = 16'h0;
    logic [3:0]  msg_en_i = 4'h0;
    logic        msg_blink_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        busy_o;
    logic        digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o;
    logic [3:0]  digit0_o, digit1_o, digit2_o, digit3_o;

    basys3_7seg_sched #(
        .HOLD_MS       (HOLD),
        .GAP_MS        (GAP),
        .BLINK_HALF_MS (HALF)
    ) dut (
        .clk_1k_i    (clk),
        .rst_i       (rst_i),
        .live_i      (live_i),
        .lz_blank_i  (lz_blank_i),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .msg_i       (msg_i),
        .msg_en_i    (msg_en_i),
        .msg_blink_i (msg_blink_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .digit0_en_o (digit0_en_o),
        .digit1_en_o (digit1_en_o),
        .digit2_en_o (digit2_en_o),
        .digit3_en_o (digit3_en_o),
        .digit0_o    (digit0_o),
        .digit1_o    (digit1_o),
        .digit2_o    (digit2_o),
        .digit3_o    (digit3_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int txn      = 0;
    logic [25:0] exp_q[$];

    // Reference model: mode 0=live 1=showing 2=gap; t = display cycle within mode (1-based)
    int          m_mode  = 0;
    int          m_t     = 0;
    logic        m_ready = 1'b0;
    logic [15:0] m_msg   = 16'h0;
    logic [3:0]  m_en    = 4'h0;
    logic        m_blink = 1'b0;

    function automatic logic [25:0] actual();
        return {msg_ready_o, busy_o, digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o,
                digit3_o, digit2_o, digit1_o, digit0_o};
    endfunction

    function automatic logic [3:0] lz_mask(input logic [15:0] v, input logic lz);
        int top = 0;
        if (!lz) return 4'hF;
        for (int k = 0; k < 4; k++)
            if (((v >> (4 * k)) & 16'hF) != 0) top = k;
        return 4'((1 << (top + 1)) - 1);
    endfunction

    task automatic model(input logic r, input logic [15:0] lv, input logic lz, input logic v,
                         input logic [15:0] m, input logic [3:0] e, input logic b, input logic ab);
        logic [3:0]  en;
        logic [15:0] val;
        logic        on;
        if (r) begin
            m_mode = 0; m_t = 0; m_ready = 1'b0;
            exp_q.push_back(26'd0);
            return;
        end
        case (m_mode)
            0: if (v && m_ready) begin
                m_mode = 1; m_t = 1; m_msg = m; m_en = e; m_blink = b;
            end
            1: if (ab) m_mode = 0;
               else if (m_t == HOLD) begin
                   if (GAP == 0) m_mode = 0;
                   else begin m_mode = 2; m_t = 1; end
               end else m_t++;
            default: if (ab || m_t == GAP) m_mode = 0; else m_t++;
        endcase
        m_ready = (m_mode == 0);
        case (m_mode)
            0: begin val = lv; en = lz_mask(lv, lz); end
            1: begin
                on  = !m_blink || (((m_t - 1) / HALF) % 2 == 0);
                val = m_msg;
                en  = on ? m_en : 4'h0;
            end
            default: begin val = 16'h0; en = 4'h0; end
        endcase
        exp_q.push_back({m_ready, !m_ready, en, val});
    endtask

    task automatic drive(input logic r, input logic [15:0] lv, input logic lz, input logic v,
                         input logic [15:0] m, input logic [3:0] e, input logic b, input logic ab);
        @(negedge clk);
        rst_i = r; live_i = lv; lz_blank_i = lz; msg_valid_i = v;
        msg_i = m; msg_en_i = e; msg_blink_i = b; abort_i = ab;
        model(r, lv, lz, v, m, e, b, ab);
    endtask

    task automatic idle(input int n, input logic [15:0] lv);
        repeat (n) drive(1'b0, lv, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    // Fixed expectations straight from the behavioural rules, read just after the edge
    task automatic expect_out(input string name, input logic [25:0] want);
        @(posedge clk);
        #2;
        chk(name, 32'(actual()), 32'(want));
    endtask

    task automatic async_reset(input int extra);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst_outputs", 32'(actual()), 32'd0);
        m_mode = 0; m_t = 0; m_ready = 1'b0;
        repeat (extra) drive(1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        logic [25:0] e;
        logic [25:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual();
                txn++;
                n_checks++;
                if (a === e) begin
                    n_pass++;
                    $display("txn %0d ok out=%h", txn, a);
                end else begin
                    $display("FAIL txn %0d outputs: got %h want %h", txn, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        #2;
        chk("reset_outputs", 32'(actual()), 32'd0);
        drive(1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 16'h1234, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        expect_out("release_live_1234", {1'b1, 1'b0, 4'hF, 16'h1234});
        idle(2, 16'h1234);
        async_reset(2);
        drive(1'b0, 16'h1234, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        expect_out("rerelease_live", {1'b1, 1'b0, 4'hF, 16'h1234});

        drive(1'b0, 16'h0050, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        expect_out("lzb_0050", {1'b1, 1'b0, 4'b0011, 16'h0050});
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        expect_out("lzb_0000", {1'b1, 1'b0, 4'b0001, 16'h0000});
        drive(1'b0, 16'h8001, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        expect_out("lzb_8001", {1'b1, 1'b0, 4'b1111, 16'h8001});

        drive(1'b0, 16'h1234, 1'b0, 1'b1, 16'hBEEF, 4'hF, 1'b0, 1'b0);
        expect_out("msg_accept", {1'b0, 1'b1, 4'hF, 16'hBEEF});
        idle(6, 16'h1234);
        idle(1, 16'h1234);
        expect_out("msg_last_hold", {1'b0, 1'b1, 4'hF, 16'hBEEF});
        idle(1, 16'h1234);
        expect_out("gap_first", {1'b0, 1'b1, 4'h0, 16'h0});
        idle(1, 16'h1234);
        expect_out("gap_second", {1'b0, 1'b1, 4'h0, 16'h0});
        idle(1, 16'h1234);
        expect_out("back_to_live", {1'b1, 1'b0, 4'hF, 16'h1234});

        drive(1'b0, 16'h1234, 1'b0, 1'b1, 16'hA5C3, 4'b0011, 1'b1, 1'b0);
        idle(12, 16'h4321);

        drive(1'b0, 16'h1111, 1'b0, 1'b1, 16'hCAFE, 4'hF, 1'b0, 1'b0);
        idle(1, 16'h1111);
        drive(1'b0, 16'h2222, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        expect_out("abort_show_c3", {1'b1, 1'b0, 4'hF, 16'h2222});
        drive(1'b0, 16'h2222, 1'b0, 1'b1, 16'h0A0A, 4'hF, 1'b0, 1'b0);
        repeat (14) drive(1'b0, 16'h3333, 1'b0, 1'b1, 16'h0B0B, 4'h6, 1'b0, 1'b0);
        drive(1'b0, 16'h3333, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        idle(12, 16'h3333);
        drive(1'b0, 16'h3333, 1'b0, 1'b1, 16'hD00D, 4'hF, 1'b0, 1'b1);
        expect_out("abort_valid_live", {1'b0, 1'b1, 4'hF, 16'hD00D});
        idle(12, 16'h3333);

        drive(1'b0, 16'h4444, 1'b0, 1'b1, 16'hF00D, 4'hF, 1'b0, 1'b0);
        idle(3, 16'h4444);
        async_reset(1);
        drive(1'b0, 16'h5678, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        expect_out("reset_mid_show_no_resume", {1'b1, 1'b0, 4'hF, 16'h5678});
        idle(2, 16'h5678);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset($urandom_range(0, 2));
            end
            drive(1'b0, 16'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                  16'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 24) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
